// File: rtl/gshare_br_predictor.sv
// gshare direction predictor: GHR XOR PC indexes a table of 2-bit saturating counters.
// The GHR shifts speculatively at fetch, is restored from a carried checkpoint on mispredict,
// and the table is cleared by a one-entry-per-cycle sweep after reset.
module gshare_br_predictor #(
    parameter int          IDX_BITS   = 10,
    parameter int          HIST_BITS  = 8,
    parameter logic [1:0]  INIT_STATE = 2'b01
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 fetch_valid,
    input  logic [31:0]          fetch_pc,
    input  logic [6:0]           fetch_opcode,
    output logic                 pred_taken,
    output logic [IDX_BITS-1:0]  pred_idx,
    output logic [HIST_BITS-1:0] pred_ghr,
    input  logic                 resolve_valid,
    input  logic                 resolve_is_br,
    input  logic                 resolve_taken,
    input  logic [IDX_BITS-1:0]  resolve_idx,
    input  logic [HIST_BITS-1:0] resolve_ghr,
    input  logic                 resolve_mispredict,
    output logic                 ready
);

    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    localparam int ENTRIES = 1 << IDX_BITS;

    logic [0:0]           state_q, state_d;
    logic [IDX_BITS-1:0]  init_ptr_q, init_ptr_d;
    logic [HIST_BITS-1:0] ghr_q, ghr_d;
    logic [1:0]           pht_q [ENTRIES];

    logic                 pht_we;
    logic [IDX_BITS-1:0]  pht_waddr;
    logic [1:0]           pht_wdata;
    logic [1:0]           pht_cur;
    logic                 fetch_is_br;
    logic                 fetch_is_jump;
    logic                 upd_en;
    logic                 unused_bits;

    assign unused_bits   = ^{fetch_pc[31:IDX_BITS+2], fetch_pc[1:0], resolve_ghr[HIST_BITS-1]};

    assign ready         = (state_q == ST_READY);
    assign fetch_is_br   = (fetch_opcode == OP_BR);
    assign fetch_is_jump = (fetch_opcode == OP_JAL) || (fetch_opcode == OP_JALR);
    assign upd_en        = ready && !stall && resolve_valid && resolve_is_br;

    assign pred_idx = fetch_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr_q);
    assign pred_ghr = ghr_q;

    // Reads the pre-update table: a same-cycle resolve to this entry is not bypassed.
    always_comb begin
        pred_taken = 1'b0;
        if (fetch_is_jump) begin
            pred_taken = 1'b1;
        end else if (fetch_is_br && ready) begin
            pred_taken = pht_q[pred_idx][1];
        end
    end

    assign pht_cur = pht_q[resolve_idx];

    always_comb begin
        pht_we    = 1'b0;
        pht_waddr = init_ptr_q;
        pht_wdata = INIT_STATE;
        if (state_q == ST_INIT) begin
            pht_we = 1'b1;
        end else if (upd_en) begin
            pht_we    = 1'b1;
            pht_waddr = resolve_idx;
            if (resolve_taken) begin
                pht_wdata = (pht_cur == 2'b11) ? 2'b11 : pht_cur + 2'd1;
            end else begin
                pht_wdata = (pht_cur == 2'b00) ? 2'b00 : pht_cur - 2'd1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        if (state_q == ST_INIT) begin
            init_ptr_d = init_ptr_q + IDX_BITS'(1);
            if (init_ptr_q == '1) begin
                state_d = ST_READY;
            end
        end
    end

    // Mispredict recovery wins over a same-cycle speculative shift.
    always_comb begin
        ghr_d = ghr_q;
        if (ready && !stall) begin
            if (upd_en && resolve_mispredict) begin
                ghr_d = {resolve_ghr[HIST_BITS-2:0], resolve_taken};
            end else if (fetch_valid && fetch_is_br) begin
                ghr_d = {ghr_q[HIST_BITS-2:0], pred_taken};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_INIT;
            init_ptr_q <= '0;
            ghr_q      <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            ghr_q      <= ghr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (pht_we) begin
            pht_q[pht_waddr] <= pht_wdata;
        end
    end

endmodule

// File: tb/tb_gshare_br_predictor.sv
// Directed bench for gshare_br_predictor (IDX_BITS=4, HIST_BITS=4) with an expectation queue.
module tb_gshare_br_predictor;

    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_ADD = 7'b0110011;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [6:0]  fetch_opcode;
    logic        pred_taken;
    logic [3:0]  pred_idx;
    logic [3:0]  pred_ghr;
    logic        resolve_valid;
    logic        resolve_is_br;
    logic        resolve_taken;
    logic [3:0]  resolve_idx;
    logic [3:0]  resolve_ghr;
    logic        resolve_mispredict;
    logic        ready;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    gshare_br_predictor #(.IDX_BITS(4), .HIST_BITS(4), .INIT_STATE(2'b01)) dut (
        .clk                (clk),
        .rst                (rst),
        .stall              (stall),
        .fetch_valid        (fetch_valid),
        .fetch_pc           (fetch_pc),
        .fetch_opcode       (fetch_opcode),
        .pred_taken         (pred_taken),
        .pred_idx           (pred_idx),
        .pred_ghr           (pred_ghr),
        .resolve_valid      (resolve_valid),
        .resolve_is_br      (resolve_is_br),
        .resolve_taken      (resolve_taken),
        .resolve_idx        (resolve_idx),
        .resolve_ghr        (resolve_ghr),
        .resolve_mispredict (resolve_mispredict),
        .ready              (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check_out(input logic [31:0] obs);
        exp_t e;
        chk_cnt++;
        if (sb.size() == 0) begin
            $error("FAIL scoreboard_empty: observed %0h, required a queued expectation", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) pass_cnt++;
            else $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.val);
        end
    endtask

    task automatic set_fetch(input logic v, input logic [6:0] op, input logic [31:0] pc);
        fetch_valid  = v;
        fetch_opcode = op;
        fetch_pc     = pc;
    endtask

    task automatic set_resolve(input logic v, input logic [3:0] idx, input logic tk,
                               input logic [3:0] ghr, input logic misp);
        resolve_valid      = v;
        resolve_is_br      = v;
        resolve_idx        = idx;
        resolve_taken      = tk;
        resolve_ghr        = ghr;
        resolve_mispredict = misp;
    endtask

    task automatic sweep_and_check(input string tag);
        int n;
        n = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
        expect_val({tag, "_sweep_cycles"}, 16);
        check_out(n);
        expect_val({tag, "_ghr_after_sweep"}, 0);
        check_out(pred_ghr);
        set_fetch(1'b0, OP_BR, 32'h0);
        for (int i = 0; i < 16; i++) begin
            fetch_pc = i << 2;
            expect_val({tag, "_idx"}, i);
            expect_val({tag, "_pred_zero"}, 0);
            #1;
            check_out(pred_idx);
            check_out(pred_taken);
        end
    endtask

    initial begin
        rst   = 1'b0;
        stall = 1'b0;
        set_fetch(1'b0, OP_ADD, 32'h0);
        set_resolve(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        tick();
        tick();
        expect_val("reset_ready", 0);
        expect_val("reset_ghr", 0);
        check_out(ready);
        check_out(pred_ghr);

        // Release reset between edges; an op_br fetch in INIT must not predict or shift.
        rst = 1'b1;
        set_fetch(1'b1, OP_BR, 32'h0);
        expect_val("init_pred_taken", 0);
        #1;
        check_out(pred_taken);
        sweep_and_check("init");

        // Training via mispredicting resolves (GHR becomes 0001 from the checkpoint).
        set_resolve(1'b1, 4'd5, 1'b1, 4'd0, 1'b1);
        tick();
        tick();
        set_resolve(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        expect_val("train_ghr", 4'b0001);
        #1;
        check_out(pred_ghr);
        set_fetch(1'b0, OP_BR, 32'h10);
        expect_val("train_idx5", 5);
        expect_val("train_pred5", 1);
        #1;
        check_out(pred_idx);
        check_out(pred_taken);
        fetch_pc = 32'h14;
        expect_val("train_idx4", 4);
        expect_val("train_pred4", 0);
        #1;
        check_out(pred_idx);
        check_out(pred_taken);

        // Restore GHR to 0 by a not-taken recovery on entry 15 (01 -> 00).
        set_resolve(1'b1, 4'd15, 1'b0, 4'd0, 1'b1);
        tick();
        set_resolve(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        expect_val("restore_ghr", 0);
        #1;
        check_out(pred_ghr);

        // Speculative history: three taken branches all landing on entry 5.
        set_fetch(1'b1, OP_BR, 32'h14);
        expect_val("spec0_ghr", 0);
        expect_val("spec0_pred", 1);
        #1;
        check_out(pred_ghr);
        check_out(pred_taken);
        tick();
        fetch_pc = 32'h10;
        expect_val("spec1_ghr", 1);
        expect_val("spec1_pred", 1);
        #1;
        check_out(pred_ghr);
        check_out(pred_taken);
        tick();
        fetch_pc = 32'h18;
        expect_val("spec2_ghr", 3);
        expect_val("spec2_pred", 1);
        #1;
        check_out(pred_ghr);
        check_out(pred_taken);
        tick();
        set_fetch(1'b1, OP_JAL, 32'h0);
        expect_val("spec_ghr_final", 4'b0111);
        expect_val("jal_pred", 1);
        #1;
        check_out(pred_ghr);
        check_out(pred_taken);
        tick();
        expect_val("jal_no_shift", 4'b0111);
        check_out(pred_ghr);

        // Stall freezes GHR and the table (entry 2 would reach 11 otherwise).
        stall = 1'b1;
        set_fetch(1'b1, OP_BR, 32'h14);
        set_resolve(1'b1, 4'd2, 1'b1, 4'd0, 1'b0);
        tick();
        tick();
        stall = 1'b0;
        set_fetch(1'b0, OP_BR, 32'h14);
        set_resolve(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        expect_val("stall_ghr", 4'b0111);
        expect_val("stall_idx2", 2);
        expect_val("stall_pht2", 0);
        #1;
        check_out(pred_ghr);
        check_out(pred_idx);
        check_out(pred_taken);

        // Recovery priority over a same-cycle fetch shift.
        set_resolve(1'b1, 4'd14, 1'b0, 4'b0101, 1'b1);
        tick();
        expect_val("prio_setup_ghr", 4'b1010);
        check_out(pred_ghr);
        set_fetch(1'b1, OP_BR, 32'h0);
        set_resolve(1'b1, 4'd13, 1'b1, 4'b0011, 1'b1);
        tick();
        set_fetch(1'b0, OP_BR, 32'h0);
        set_resolve(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        expect_val("prio_ghr", 4'b0111);
        check_out(pred_ghr);

        // Same-index collision on entry 3: prediction sees the pre-update value.
        set_fetch(1'b0, OP_BR, 32'h10);
        set_resolve(1'b1, 4'd3, 1'b1, 4'd0, 1'b0);
        expect_val("coll_idx", 3);
        expect_val("coll_pred_old", 0);
        #1;
        check_out(pred_idx);
        check_out(pred_taken);
        tick();
        set_resolve(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        expect_val("coll_pred_new", 1);
        #1;
        check_out(pred_taken);

        // Saturation at 11: taken, then two not-taken -> 01 (predict 0).
        set_resolve(1'b1, 4'd5, 1'b1, 4'd0, 1'b0);
        tick();
        resolve_taken = 1'b0;
        tick();
        tick();
        set_resolve(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        set_fetch(1'b0, OP_BR, 32'h08);
        expect_val("sat_hi_idx", 5);
        expect_val("sat_hi_pred", 0);
        #1;
        check_out(pred_idx);
        check_out(pred_taken);

        // Saturation at 00: not-taken on entry 15 stays 00 (predict 0).
        set_resolve(1'b1, 4'd15, 1'b0, 4'd0, 1'b0);
        tick();
        set_resolve(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        set_fetch(1'b0, OP_BR, 32'h20);
        expect_val("sat_lo_idx", 15);
        expect_val("sat_lo_pred", 0);
        #1;
        check_out(pred_idx);
        check_out(pred_taken);

        // Asynchronous reset between edges, then a full re-sweep.
        rst = 1'b0;
        expect_val("async_ready", 0);
        expect_val("async_ghr", 0);
        expect_val("async_pred", 0);
        #1;
        check_out(ready);
        check_out(pred_ghr);
        check_out(pred_taken);
        tick();
        tick();
        rst = 1'b1;
        sweep_and_check("resweep");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
